// File: rtl/regfl_mp.sv
// regfl_mp: parameterised flop-based register file with one byte-masked write port,
// two registered write-first read ports and a sequential clear-all sweep.
module regfl_mp #(
  parameter int W = 64,
  parameter int A = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           we,
  input  logic [A-1:0]   waddr,
  input  logic [W-1:0]   wdata,
  input  logic [W/8-1:0] wmask,
  input  logic [A-1:0]   raddr0,
  input  logic [A-1:0]   raddr1,
  input  logic           clr,
  output logic [W-1:0]   rdata0,
  output logic [W-1:0]   rdata1,
  output logic           busy,
  output logic           done
);

  localparam int N = 1 << A;
  localparam int B = W / 8;
  localparam logic [A-1:0] LAST = A'(N - 1);

  typedef enum logic {
    IDLE,
    CLEAR
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic [A-1:0]   ptr;
  logic [A-1:0]   ptr_nxt;
  logic           done_nxt;
  logic           wr_en;
  logic           clr_en;
  logic [W-1:0]   mem [N];
  logic [W-1:0]   merged;
  logic [W-1:0]   rd0_nxt;
  logic [W-1:0]   rd1_nxt;

  // clr has priority over we in IDLE; everything else is ignored while sweeping
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    done_nxt  = 1'b0;
    wr_en     = 1'b0;
    clr_en    = 1'b0;
    case (state)
      IDLE: begin
        if (clr) begin
          state_nxt = CLEAR;
          ptr_nxt   = '0;
        end else begin
          wr_en = we;
        end
      end
      CLEAR: begin
        clr_en  = 1'b1;
        ptr_nxt = ptr + A'(1);
        if (ptr == LAST) begin
          state_nxt = IDLE;
          ptr_nxt   = '0;
          done_nxt  = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        ptr_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      done  <= done_nxt;
    end
  end

  assign busy = (state == CLEAR);

  always_comb begin
    merged = mem[waddr];
    for (int b = 0; b < B; b++) begin
      if (wmask[b]) begin
        merged[8*b +: 8] = wdata[8*b +: 8];
      end
    end
  end

  // Read data reflects the entry as it will be after this edge (write-first)
  always_comb begin
    rd0_nxt = mem[raddr0];
    rd1_nxt = mem[raddr1];
    if (wr_en && (waddr == raddr0)) begin
      rd0_nxt = merged;
    end else if (clr_en && (ptr == raddr0)) begin
      rd0_nxt = '0;
    end
    if (wr_en && (waddr == raddr1)) begin
      rd1_nxt = merged;
    end else if (clr_en && (ptr == raddr1)) begin
      rd1_nxt = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata0 <= '0;
      rdata1 <= '0;
      for (int i = 0; i < N; i++) begin
        mem[i] <= '0;
      end
    end else begin
      rdata0 <= rd0_nxt;
      rdata1 <= rd1_nxt;
      if (wr_en) begin
        mem[waddr] <= merged;
      end
      if (clr_en) begin
        mem[ptr] <= '0;
      end
    end
  end

endmodule

// File: tb/tb_regfl_mp.sv
// tb_regfl_mp: directed plus randomized checks of regfl_mp against an
// array-based model that applies each edge's update, then reads the array.
module tb_regfl_mp;

  localparam int W = 64;
  localparam int A = 3;
  localparam int N = 1 << A;
  localparam int B = W / 8;

  logic           clk = 1'b0;
  logic           rst;
  logic           we;
  logic [A-1:0]   waddr;
  logic [W-1:0]   wdata;
  logic [B-1:0]   wmask;
  logic [A-1:0]   raddr0;
  logic [A-1:0]   raddr1;
  logic           clr;
  logic [W-1:0]   rdata0;
  logic [W-1:0]   rdata1;
  logic           busy;
  logic           done;

  always #5 clk = ~clk;

  regfl_mp #(.W(W), .A(A)) dut (
    .clk    (clk),
    .rst    (rst),
    .we     (we),
    .waddr  (waddr),
    .wdata  (wdata),
    .wmask  (wmask),
    .raddr0 (raddr0),
    .raddr1 (raddr1),
    .clr    (clr),
    .rdata0 (rdata0),
    .rdata1 (rdata1),
    .busy   (busy),
    .done   (done)
  );

  logic [W-1:0] model_mem [N];
  bit           sweeping;
  int           sweep_idx;
  logic [W-1:0] exp_rd0;
  logic [W-1:0] exp_rd1;
  logic         exp_done;
  int           n_checks = 0;
  int           n_fail   = 0;
  int           busy_cnt;
  int           done_cnt;

  task automatic check_val(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Model of one clock edge: reset, else sweep step, else clr start, else masked write
  task automatic model_step();
    if (rst) begin
      for (int i = 0; i < N; i++) model_mem[i] = '0;
      sweeping  = 1'b0;
      sweep_idx = 0;
      exp_done  = 1'b0;
    end else begin
      exp_done = 1'b0;
      if (sweeping) begin
        model_mem[sweep_idx] = '0;
        if (sweep_idx == N - 1) begin
          sweeping = 1'b0;
          exp_done = 1'b1;
        end else begin
          sweep_idx++;
        end
      end else if (clr) begin
        sweeping  = 1'b1;
        sweep_idx = 0;
      end else if (we) begin
        for (int b = 0; b < B; b++)
          if (wmask[b]) model_mem[waddr][8*b +: 8] = wdata[8*b +: 8];
      end
    end
    exp_rd0 = model_mem[raddr0];
    exp_rd1 = model_mem[raddr1];
  endtask

  task automatic checkOutput();
    check_val("rdata0", rdata0, exp_rd0);
    check_val("rdata1", rdata1, exp_rd1);
    check_val("busy", W'(busy), W'(sweeping));
    check_val("done", W'(done), W'(exp_done));
    check_val("busy_done_excl", W'(busy & done), '0);
  endtask

  task automatic applyStimulus(input logic r, input logic c, input logic w,
                               input logic [A-1:0] wa, input logic [W-1:0] wd,
                               input logic [B-1:0] wm,
                               input logic [A-1:0] ra0, input logic [A-1:0] ra1);
    rst    = r;
    clr    = c;
    we     = w;
    waddr  = wa;
    wdata  = wd;
    wmask  = wm;
    raddr0 = ra0;
    raddr1 = ra1;
    @(posedge clk);
    model_step();
    #1;
    checkOutput();
    if (busy) busy_cnt++;
    if (done) done_cnt++;
  endtask

  initial begin
    for (int i = 0; i < N; i++) model_mem[i] = '0;
    sweeping = 1'b0;
    sweep_idx = 0;
    exp_done = 1'b0;
    rst = 1'b1; clr = 1'b0; we = 1'b0; waddr = '0; wdata = '0; wmask = '0;
    raddr0 = '0; raddr1 = '0;
    $display("[TB] start W=%0d A=%0d", W, A);

    // Reset, then read every address on both ports
    applyStimulus(1'b1, 1'b0, 1'b0, '0, '0, '0, '0, '0);
    applyStimulus(1'b1, 1'b0, 1'b0, '0, '0, '0, '0, '0);
    for (int i = 0; i < N; i++)
      applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, '0, A'(i), A'(N - 1 - i));

    // Full write then low-half masked overwrite of entry 5
    applyStimulus(1'b0, 1'b0, 1'b1, 3'd5, 64'h1122334455667788, 8'hFF, 3'd5, 3'd0);
    check_val("full_write", rdata0, 64'h1122334455667788);
    applyStimulus(1'b0, 1'b0, 1'b1, 3'd5, 64'hAAAAAAAAAAAAAAAA, 8'h0F, 3'd5, 3'd5);
    check_val("masked_merge", rdata0, 64'h11223344AAAAAAAA);
    applyStimulus(1'b0, 1'b0, 1'b1, 3'd5, 64'hFFFFFFFFFFFFFFFF, 8'h00, 3'd5, 3'd1);
    check_val("zero_mask_noop", rdata0, 64'h11223344AAAAAAAA);

    // Same-cycle write/read bypass on both ports
    applyStimulus(1'b0, 1'b0, 1'b1, 3'd2, 64'hDEAD, 8'hFF, 3'd2, 3'd2);
    check_val("bypass_p0", rdata0, 64'h000000000000DEAD);
    check_val("bypass_p1", rdata1, 64'h000000000000DEAD);

    // Fill with i+1, then sweep with writes and clr attempted while busy
    for (int i = 0; i < N; i++)
      applyStimulus(1'b0, 1'b0, 1'b1, A'(i), W'(i + 1), '1, A'(i), A'(i));
    busy_cnt = 0;
    done_cnt = 0;
    applyStimulus(1'b0, 1'b1, 1'b1, 3'd4, 64'h5555, 8'hFF, 3'd4, 3'd4);
    check_val("clr_drops_write", rdata0, 64'd5);
    for (int i = 0; i < N; i++)
      applyStimulus(1'b0, (i == 2), 1'b1, 3'd7, 64'h77, 8'hFF, 3'd7, A'(i));
    check_val("sweep_len", W'(busy_cnt), W'(N));
    check_val("done_pulses", W'(done_cnt), 64'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, '0, 3'd0, 3'd7);
    check_val("done_drops", W'(done), '0);
    for (int i = 0; i < N; i++)
      applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, '0, A'(i), A'(i));

    // Reset three cycles into a sweep
    for (int i = 0; i < N; i++)
      applyStimulus(1'b0, 1'b0, 1'b1, A'(i), {$urandom, $urandom}, '1, A'(i), '0);
    done_cnt = 0;
    applyStimulus(1'b0, 1'b1, 1'b0, '0, '0, '0, '0, '0);
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, '0, 3'd6, 3'd7);
    applyStimulus(1'b1, 1'b0, 1'b0, '0, '0, '0, 3'd6, 3'd7);
    for (int i = 0; i < N; i++)
      applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, '0, A'(i), A'(N - 1 - i));
    check_val("no_done_after_rst", W'(done_cnt), '0);

    // Randomized traffic with occasional clr and rare reset
    for (int n = 0; n < 600; n++)
      applyStimulus(($urandom_range(0, 99) == 0), ($urandom_range(0, 24) == 0),
                     $urandom_range(0, 1) == 1, A'($urandom), {$urandom, $urandom},
                     B'($urandom), A'($urandom), A'($urandom));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
